decoder_3to8: RTL and testbench

3-to-8 one-hot binary decoder with a small registered tracking stage. The combinational core turns a 3-bit code (a = MSB, c = LSB) into eight active-high one-hot lines d0..d7. A clocked side path records the last decoded code and, optionally, which codes have been decoded since reset. It is a leaf utility block for address/select decoding in the datapath.

---
 rtl/decoder_3to8.sv | 92 +++++++++
 tb/tb_decoder_3to8.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3to8
//  Description : 3-to-8 one-hot decoder with a registered tracking side path.
//                d0..d7 are purely combinational. code_q holds the code seen
//                at the last rising edge. Optional hit/all_hit tracking is
//                enabled by defining DECODER_HIT_TRACK_EN; otherwise those
//                outputs are tied low and build no flops.
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_3to8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic       d5,
    output logic       d6,
    output logic       d7,
    output logic [2:0] code_q,
    output logic [7:0] hit,
    output logic       all_hit
);

    localparam int unsigned C_NUM_LINES = 8;

    logic [2:0]             sel_w;
    logic [C_NUM_LINES-1:0] dec_w;
    logic [2:0]             code_d;

    assign sel_w  = {a, b, c};
    assign code_d = sel_w;

    // One comparator per output line; exactly one matches for any 2-state code
    for (genvar i = 0; i < C_NUM_LINES; i++) begin : g_dec
        assign dec_w[i] = (sel_w == 3'(i));
    end

    assign d0 = dec_w[0];
    assign d1 = dec_w[1];
    assign d2 = dec_w[2];
    assign d3 = dec_w[3];
    assign d4 = dec_w[4];
    assign d5 = dec_w[5];
    assign d6 = dec_w[6];
    assign d7 = dec_w[7];

    // Capture the code presented at each edge; reset returns it to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= 3'b000;
        end else begin
            code_q <= code_d;
        end
    end

`ifdef DECODER_HIT_TRACK_EN
    logic [C_NUM_LINES-1:0] hit_q;
    logic [C_NUM_LINES-1:0] hit_d;
    logic                   all_hit_q;
    logic                   all_hit_d;

    // The code sampled this edge is folded in, so all_hit rises on the same
    // edge that sets the final hit bit rather than one cycle later
    assign hit_d     = hit_q | dec_w;
    assign all_hit_d = &hit_d;

    // Sticky coverage mask; only reset clears it, and reset wins over a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= '0;
            all_hit_q <= 1'b0;
        end else begin
            hit_q     <= hit_d;
            all_hit_q <= all_hit_d;
        end
    end

    assign hit     = hit_q;
    assign all_hit = all_hit_q;
`else
    assign hit     = 8'h00;
    assign all_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_3to8
//  Description : Self-checking bench for decoder_3to8. Expected outputs are
//                pushed to a scoreboard queue as stimulus is driven and popped
//                when the DUT outputs are sampled. Hit tracking expectations
//                follow DECODER_HIT_TRACK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic       a, b, c;
    logic       d0, d1, d2, d3, d4, d5, d6, d7;
    logic [2:0] code_q;
    logic [7:0] hit;
    logic       all_hit;
    bit         clk_en;

    decoder_3to8 dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4),
        .d5      (d5),
        .d6      (d6),
        .d7      (d7),
        .code_q  (code_q),
        .hit     (hit),
        .all_hit (all_hit)
    );

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic [2:0] code;
        logic [7:0] hit;
        logic       all;
        bit         chk_reg;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state for the registered path
    logic [2:0] m_code;
    logic [7:0] m_hit;
    logic       m_all;
    bit         m_valid;

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input string tag, input logic [2:0] abc);
        exp_t e;
        e.tag     = tag;
        e.d       = 8'(1) << abc;
        e.code    = m_code;
        e.hit     = m_hit;
        e.all     = m_all;
        e.chk_reg = m_valid;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t       e;
        logic [7:0] dv;
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL sb_empty: observed no expectation, required one");
            return;
        end
        e  = sb.pop_front();
        dv = {d7, d6, d5, d4, d3, d2, d1, d0};
        n_chk++;
        assert (dv === e.d) n_pass++;
        else $error("FAIL %s d: observed %b expected %b", e.tag, dv, e.d);
        if (e.chk_reg) begin
            n_chk++;
            assert (code_q === e.code) n_pass++;
            else $error("FAIL %s code_q: observed %0d expected %0d", e.tag, code_q, e.code);
            n_chk++;
            assert (hit === e.hit) n_pass++;
            else $error("FAIL %s hit: observed %h expected %h", e.tag, hit, e.hit);
            n_chk++;
            assert (all_hit === e.all) n_pass++;
            else $error("FAIL %s all_hit: observed %b expected %b", e.tag, all_hit, e.all);
        end
    endtask

    // Apply a code and rst level for one cycle; check decode before the edge
    // and registered state after it
    task automatic step(input string tag, input logic [2:0] abc, input logic r);
        logic [7:0] nh;
        @(negedge clk);
        {a, b, c} = abc;
        rst       = r;
        #1;
        push_exp({tag, "_pre"}, abc);
        compare_out();
        @(posedge clk);
        if (r) begin
            m_code = 3'b000;
            m_hit  = 8'h00;
            m_all  = 1'b0;
        end else begin
            m_code = abc;
`ifdef DECODER_HIT_TRACK_EN
            nh     = m_hit | (8'(1) << abc);
            m_hit  = nh;
            m_all  = (nh == 8'hFF);
`else
            nh     = 8'h00;
            m_hit  = nh;
            m_all  = 1'b0;
`endif
        end
        m_valid = 1'b1;
        #1;
        push_exp({tag, "_post"}, abc);
        compare_out();
    endtask

    initial begin
        clk_en  = 1'b0;
        rst     = 1'b0;
        {a, b, c} = 3'b000;
        m_code  = 3'b000;
        m_hit   = 8'h00;
        m_all   = 1'b0;
        m_valid = 1'b0;

        // Combinational sweep with no clock or reset activity
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            push_exp($sformatf("sweep%0d", i), 3'(i));
            #5;
            compare_out();
        end

        clk_en = 1'b1;

        // Reset held for two edges; d5 keeps following the input
        step("rst0", 3'b101, 1'b1);
        step("rst1", 3'b101, 1'b1);

        // First post-reset edge samples normally
        step("first", 3'b011, 1'b0);

        // Visit every code; coverage completes on the edge sampling code 7
        for (int i = 0; i < 8; i++) begin
            step($sformatf("all%0d", i), 3'(i), 1'b0);
        end

        // Repeats leave the sticky state unchanged
        step("rep2", 3'b010, 1'b0);
        step("rep7", 3'b111, 1'b0);

        // Reset wins over a same-cycle sample of code 7
        step("midrst", 3'b111, 1'b1);

        // Operation resumes after mid-run reset
        step("resume", 3'b100, 1'b0);
        step("resume2", 3'b001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
